// File: rtl/ft2232h_pkg.sv
// Shared types and constants for the FT2232H sync-FIFO bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ft2232h_pkg;

    localparam int DEF_BURST_MAX = 64;
    localparam int RXBUF_ENTRIES = 4;
    localparam int RXBUF_AW      = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_OE    = 3'd1,
        ST_RX_READ  = 3'd2,
        ST_RX_TURN  = 3'd3,
        ST_TX_WRITE = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_RX = 1'b0,
        GRANT_TX = 1'b1
    } grant_t;

    // Increment a burst counter, holding it at the limit once reached.
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc,
                                           input logic [7:0] lim);
        if (inc && (v < lim)) begin
            return v + 8'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/ft2232h_rx_buf.sv
// 4x8 RX holding FIFO between the FT2232H pads and the RX stream.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: none internally; the arbiter stops reading while count is high.
module ft2232h_rx_buf
    import ft2232h_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic [7:0]          push_dat_i,
    input  logic                pop_i,
    output logic [7:0]          head_dat_o,
    output logic [RXBUF_AW:0]   count_o,
    output logic                empty_o
);

    logic [7:0]          mem_q [RXBUF_ENTRIES];
    logic [RXBUF_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [RXBUF_AW:0]   count_q;
    logic                pop_ok;

    assign pop_ok     = pop_i & (count_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

    // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (RXBUF_AW+1)'(push_i) - (RXBUF_AW+1)'(pop_ok);
        end
    end

    // Storage array; contents are don't-care while empty so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // The arbiter must never push into a full buffer unless a pop frees a slot.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_ok && (count_q == (RXBUF_AW+1)'(RXBUF_ENTRIES))));

endmodule

// File: rtl/ft2232h_bus_arbiter.sv
// Arbitrates the FT2232H sync-FIFO bus between host->FPGA reads and FPGA->host writes.
// Latency: grant one cycle after request seen in IDLE (two after reset release); RX word reaches stream one cycle after capture.
// Backpressure: RX reads pause when the holding buffer fills; TX words are held and re-presented while txe_n is high.
module ft2232h_bus_arbiter
    import ft2232h_pkg::*;
#(
    parameter int BURST_MAX   = DEF_BURST_MAX,
    parameter int RXBUF_DEPTH = RXBUF_ENTRIES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxf_n,
    input  logic       txe_n,
    input  logic [7:0] adbus_in,
    output logic [7:0] adbus_out,
    output logic       adbus_oe,
    output logic       rd_n,
    output logic       wr_n,
    output logic       oe_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready
);

    localparam logic [7:0]          BURST_LIM = 8'(BURST_MAX);
    localparam logic [RXBUF_AW:0]   RX_ROOM   = (RXBUF_AW+1)'(RXBUF_DEPTH - 2);

    state_t            state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [7:0]        burst_q, burst_d, burst_inc;
    logic [7:0]        hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              rd_n_q, rd_n_d, wr_n_q, wr_n_d, oe_n_q, oe_n_d;
    logic              adbus_oe_q, adbus_oe_d;
    logic [7:0]        adbus_out_q, adbus_out_d;
    logic              armed_q;
    logic              rx_push, rx_pop, tx_take, tx_hs;
    logic              rx_empty, rx_ok, tx_ok, rd_more;
    logic [RXBUF_AW:0] rx_cnt, rx_cnt_post;

    // A word moves on the pads only on an edge where both sides have their strobe/flag low.
    assign rx_push     = ~rd_n_q & ~rxf_n;
    assign tx_take     = ~wr_n_q & ~txe_n;
    assign rx_pop      = ~rx_empty & rx_ready;
    assign rx_valid    = ~rx_empty;
    assign tx_ready    = ~hold_vld_q | tx_take;
    assign tx_hs       = tx_valid & tx_ready;
    assign rx_cnt_post = rx_cnt + (RXBUF_AW+1)'(rx_push) - (RXBUF_AW+1)'(rx_pop);
    assign burst_inc   = sat_inc(burst_q, rx_push | tx_take, BURST_LIM);

    assign rx_ok   = armed_q & ~rxf_n & (rx_cnt <= RX_ROOM);
    assign tx_ok   = armed_q & ~txe_n & hold_vld_q;
    // Keep reading only while a further word is guaranteed a free buffer slot.
    assign rd_more = ~rxf_n & (rx_cnt_post <= RX_ROOM) & (burst_inc < BURST_LIM);

    assign hold_vld_d = (hold_vld_q & ~tx_take) | tx_hs;
    assign hold_d     = tx_hs ? tx_data : hold_q;

    assign adbus_out = adbus_out_q;
    assign adbus_oe  = adbus_oe_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign oe_n      = oe_n_q;

    ft2232h_rx_buf u_rx_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (rx_push),
        .push_dat_i (adbus_in),
        .pop_i      (rx_pop),
        .head_dat_o (rx_data),
        .count_o    (rx_cnt),
        .empty_o    (rx_empty)
    );

    // State, grant history, burst count, TX hold and registered pad outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_TX;
            burst_q      <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            adbus_oe_q   <= 1'b0;
            adbus_out_q  <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_q      <= burst_d;
            hold_q       <= hold_d;
            hold_vld_q   <= hold_vld_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            oe_n_q       <= oe_n_d;
            adbus_oe_q   <= adbus_oe_d;
            adbus_out_q  <= adbus_out_d;
            armed_q      <= 1'b1;
        end
    end

    // Next-state: round-robin grant in IDLE, fixed RX bus turnaround, TX burst exit rules.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_d      = burst_inc;
        case (state_q)
            ST_IDLE: begin
                if (rx_ok && (!tx_ok || (last_grant_q == GRANT_TX))) begin
                    state_d      = ST_RX_OE;
                    last_grant_d = GRANT_RX;
                    burst_d      = '0;
                end else if (tx_ok) begin
                    state_d = ST_TX_WRITE;
                    burst_d = '0;
                end
            end
            ST_RX_OE:   state_d = ST_RX_READ;
            ST_RX_READ: if (!rd_more) state_d = ST_RX_TURN;
            ST_RX_TURN: state_d = ST_IDLE;
            ST_TX_WRITE: begin
                if (txe_n || !hold_vld_d || (burst_inc >= BURST_LIM)) begin
                    state_d      = ST_IDLE;
                    last_grant_d = GRANT_TX;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pad strobes for the coming cycle, derived from the state being entered.
    always_comb begin
        rd_n_d      = 1'b1;
        wr_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        adbus_oe_d  = 1'b0;
        adbus_out_d = adbus_out_q;
        case (state_d)
            ST_RX_OE: oe_n_d = 1'b0;
            ST_RX_READ: begin
                oe_n_d = 1'b0;
                rd_n_d = ~rd_more;
            end
            ST_TX_WRITE: begin
                adbus_oe_d  = 1'b1;
                wr_n_d      = ~hold_vld_d;
                adbus_out_d = hold_d;
            end
            default: ;
        endcase
    end

    // FPGA and FT2232H must never drive the data bus at the same time.
    assert property (@(posedge clk) disable iff (!rst_n) !(adbus_oe_q && !oe_n_q));

endmodule

// File: tb/tb_ft2232h_bus_arbiter.sv
module tb_ft2232h_bus_arbiter;
    import ft2232h_pkg::*;

    localparam int BMAX = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxf_n = 1'b1;
    logic       txe_n = 1'b1;
    logic [7:0] adbus_in = 8'h00;
    logic [7:0] adbus_out;
    logic       adbus_oe, rd_n, wr_n, oe_n;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;

    ft2232h_bus_arbiter #(.BURST_MAX(BMAX), .RXBUF_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rxf_n(rxf_n), .txe_n(txe_n),
        .adbus_in(adbus_in), .adbus_out(adbus_out), .adbus_oe(adbus_oe),
        .rd_n(rd_n), .wr_n(wr_n), .oe_n(oe_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    // FT2232H model state and stream endpoints
    logic [7:0] ft_rx_q[$];   // bytes the FT still holds for the FPGA
    logic [7:0] ft_tx_q[$];   // bytes the FT has accepted from the FPGA
    logic [7:0] src_q[$];     // TX stream source
    logic [7:0] got_q[$];     // RX stream sink
    state_t     st_hist[$];
    string      fires;
    bit         rx_rdy_en = 1'b1;
    bit         txe_blk = 1'b0;
    bit         stalled = 1'b0;
    int         stall_at = -1;
    int         cyc = 0, first_oe = -1, first_rd = -1, pres04 = 0, overlap = 0;
    int         total = 0, bad = 0;

    task automatic drive();
        rxf_n = (ft_rx_q.size() == 0);
        if (ft_rx_q.size() != 0) adbus_in = ft_rx_q[0];
        else adbus_in = 8'h00;
        txe_n = txe_blk;
        if (stall_at >= 0 && !stalled && ft_tx_q.size() == stall_at && !wr_n) begin
            txe_n   = 1'b1;
            stalled = 1'b1;
        end
        tx_valid = (src_q.size() != 0);
        if (src_q.size() != 0) tx_data = src_q[0];
        else tx_data = 8'h00;
        rx_ready = rx_rdy_en;
    endtask

    task automatic kick();
        drive();
        #1;
    endtask

    // Called between negedge+1 and the next posedge: samples what the DUT will see at the edge.
    task automatic step();
        bit rx_fire, tx_fire, t_hs, r_hs;
        logic [7:0] t_word, r_word, dummy;
        rx_fire = !rd_n && !rxf_n;
        tx_fire = !wr_n && !txe_n;
        t_hs    = tx_valid && tx_ready;
        r_hs    = rx_valid && rx_ready;
        t_word  = adbus_out;
        r_word  = rx_data;
        if (adbus_oe && !oe_n) overlap++;
        if (!oe_n && first_oe < 0) first_oe = cyc;
        if (!rd_n && first_rd < 0) first_rd = cyc;
        if (!wr_n && adbus_out == 8'h04) pres04++;
        st_hist.push_back(dut.state_q);
        @(negedge clk);
        cyc++;
        if (rx_fire) begin dummy = ft_rx_q.pop_front(); fires = {fires, "R"}; end
        if (tx_fire) begin ft_tx_q.push_back(t_word); fires = {fires, "T"}; end
        if (t_hs) dummy = src_q.pop_front();
        if (r_hs) got_q.push_back(r_word);
        kick();
    endtask

    task automatic test_reset();
        #12;
        total++; if (rd_n !== 1'b1) begin bad++; $display("FAIL reset_rd_n got=%b want=1", rd_n); end
        total++; if (wr_n !== 1'b1) begin bad++; $display("FAIL reset_wr_n got=%b want=1", wr_n); end
        total++; if (oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n got=%b want=1", oe_n); end
        total++; if (adbus_oe !== 1'b0) begin bad++; $display("FAIL reset_adbus_oe got=%b want=0", adbus_oe); end
        total++; if (adbus_out !== 8'h00) begin bad++; $display("FAIL reset_adbus_out got=%h want=00", adbus_out); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        kick();
    endtask

    task automatic test_rx_only();
        int n, last_rd;
        logic [7:0] exp;
        for (int i = 0; i < 10; i++) ft_rx_q.push_back(8'(8'h45 + i));
        got_q.delete(); st_hist.delete();
        rx_rdy_en = 1'b1; first_oe = -1; first_rd = -1; cyc = 0;
        kick();
        n = 0;
        while (got_q.size() < 10 && n < 200) begin step(); n++; end
        if (n == 200) begin total++; bad++; $display("FAIL rx_only_timeout got=%0d want=10", got_q.size()); end
        for (int i = 0; i < 4; i++) step();
        total++; if (got_q.size() != 10) begin bad++; $display("FAIL rx_only_count got=%0d want=10", got_q.size()); end
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            exp = 8'(8'h45 + i);
            total++; if (got_q[i] !== exp) begin bad++; $display("FAIL rx_only_data[%0d] got=%h want=%h", i, got_q[i], exp); end
        end
        total++; if (first_rd - first_oe != 1) begin bad++; $display("FAIL rx_only_oe_lead got=%0d want=1", first_rd - first_oe); end
        last_rd = -1;
        for (int i = 0; i < st_hist.size(); i++) if (st_hist[i] == ST_RX_READ) last_rd = i;
        total++;
        if (last_rd < 0 || last_rd + 2 >= st_hist.size()) begin
            bad++; $display("FAIL rx_only_turn got=no_read_end want=RX_TURN_IDLE");
        end else if (st_hist[last_rd+1] != ST_RX_TURN || st_hist[last_rd+2] != ST_IDLE) begin
            bad++; $display("FAIL rx_only_turn got=%0d,%0d want=%0d,%0d", st_hist[last_rd+1], st_hist[last_rd+2], ST_RX_TURN, ST_IDLE);
        end
    endtask

    task automatic test_rx_backpressure();
        int n;
        logic [7:0] exp;
        for (int i = 0; i < 6; i++) ft_rx_q.push_back(8'(8'h10 + i));
        got_q.delete();
        rx_rdy_en = 1'b0;
        kick();
        for (int i = 0; i < 20; i++) step();
        total++; if (ft_rx_q.size() != 3) begin bad++; $display("FAIL bp_captured got=%0d want=3", 6 - ft_rx_q.size()); end
        total++; if (rd_n !== 1'b1) begin bad++; $display("FAIL bp_rd_n got=%b want=1", rd_n); end
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h10) begin bad++; $display("FAIL bp_head got=%b/%h want=1/10", rx_valid, rx_data); end
        rx_rdy_en = 1'b1;
        kick();
        n = 0;
        while (got_q.size() < 6 && n < 200) begin step(); n++; end
        if (n == 200) begin total++; bad++; $display("FAIL bp_timeout got=%0d want=6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            exp = 8'(8'h10 + i);
            total++; if (got_q[i] !== exp) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", i, got_q[i], exp); end
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_tx_stall();
        int n;
        logic [7:0] exp;
        for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
        ft_tx_q.delete();
        txe_blk = 1'b0; stall_at = 3; stalled = 1'b0; pres04 = 0;
        kick();
        n = 0;
        while (ft_tx_q.size() < 8 && n < 200) begin step(); n++; end
        if (n == 200) begin total++; bad++; $display("FAIL stall_timeout got=%0d want=8", ft_tx_q.size()); end
        for (int i = 0; i < 4; i++) step();
        stall_at = -1;
        total++; if (ft_tx_q.size() != 8) begin bad++; $display("FAIL stall_count got=%0d want=8", ft_tx_q.size()); end
        for (int i = 0; i < 8 && i < ft_tx_q.size(); i++) begin
            exp = 8'(i + 1);
            total++; if (ft_tx_q[i] !== exp) begin bad++; $display("FAIL stall_data[%0d] got=%h want=%h", i, ft_tx_q[i], exp); end
        end
        total++; if (pres04 != 2) begin bad++; $display("FAIL stall_represent got=%0d want=2", pres04); end
    endtask

    task automatic test_contention();
        int n;
        for (int i = 0; i < 8; i++) begin
            ft_rx_q.push_back(8'(8'h80 + i));
            src_q.push_back(8'(8'hA0 + i));
        end
        got_q.delete(); ft_tx_q.delete(); fires = "";
        rx_rdy_en = 1'b1; txe_blk = 1'b0;
        kick();
        n = 0;
        while (fires.len() < 16 && n < 300) begin step(); n++; end
        if (n == 300) begin total++; bad++; $display("FAIL cont_timeout got=%0d want=16", fires.len()); end
        for (int i = 0; i < 4; i++) step();
        total++; if (fires != "RRRRTTTTRRRRTTTT") begin bad++; $display("FAIL cont_order got=%s want=RRRRTTTTRRRRTTTT", fires); end
        total++; if (got_q.size() != 8 || got_q[7] !== 8'h87) begin bad++; $display("FAIL cont_rx got=%0d words want=8 ending 87", got_q.size()); end
        total++; if (ft_tx_q.size() != 8 || ft_tx_q[7] !== 8'hA7) begin bad++; $display("FAIL cont_tx got=%0d words want=8 ending a7", ft_tx_q.size()); end
        total++; if (overlap != 0) begin bad++; $display("FAIL bus_overlap got=%0d want=0", overlap); end
    endtask

    task automatic test_reset_mid_tx();
        int n;
        for (int i = 0; i < 6; i++) src_q.push_back(8'(8'h31 + i));
        ft_tx_q.delete();
        kick();
        n = 0;
        while (!(ft_tx_q.size() == 2 && !wr_n) && n < 100) begin step(); n++; end
        if (n == 100) begin total++; bad++; $display("FAIL rst_tx_timeout got=%0d want=2", ft_tx_q.size()); end
        rst_n = 1'b0;
        #1;
        total++; if (wr_n !== 1'b1) begin bad++; $display("FAIL rst_wr_n got=%b want=1", wr_n); end
        total++; if (adbus_oe !== 1'b0) begin bad++; $display("FAIL rst_adbus_oe got=%b want=0", adbus_oe); end
        src_q.delete();
        ft_rx_q.delete();
        ft_rx_q.push_back(8'h55);
        kick();
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got=%b want=1", tx_ready); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b want=0", rx_valid); end
        total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dut.state_q, ST_IDLE); end
        @(posedge clk); #1;
        total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL rst_edge1 got=%0d want=%0d", dut.state_q, ST_IDLE); end
        @(posedge clk); #1;
        total++; if (dut.state_q !== ST_RX_OE) begin bad++; $display("FAIL rst_edge2 got=%0d want=%0d", dut.state_q, ST_RX_OE); end
    endtask

    initial begin
        test_reset();
        test_rx_only();
        test_rx_backpressure();
        test_tx_stall();
        test_contention();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ft2232h_bus_arbiter.md
FT2232H_BUS_ARBITER -- requirements
Module: ft2232h_bus_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 64: max words moved per grant before arbitration is re-run; legal range 1-255.
REQ-002 Parameter RXBUF_DEPTH, default 4: RX holding buffer entries; fixed at 4 for this revision.
REQ-003 clk  in  1  60 MHz CLKOUT from FT2232H; single clock domain, all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rxf_n  in  1  low = FT2232H holds host data to read.
REQ-006 txe_n  in  1  low = FT2232H TX FIFO has space.
REQ-007 adbus_in  in  8  data bus from pads.
REQ-008 adbus_out  out  8  data bus to pads, registered.
REQ-009 adbus_oe  out  1  high = FPGA drives pads, registered.
REQ-010 rd_n / wr_n / oe_n  out  1 each  FT2232H strobes, active-low, registered.
REQ-011 tx_data  in  8 / tx_valid  in  1 / tx_ready  out  1: TX stream; transfer when tx_valid & tx_ready.
REQ-012 rx_data  out  8 / rx_valid  out  1 / rx_ready  in  1: RX stream; transfer when rx_valid & rx_ready.

Function
REQ-013 FSM states: IDLE, RX_OE, RX_READ, RX_TURN, TX_WRITE; one-hot or binary encoding is free.
REQ-014 Sub-cycle strobes: IDLE all high, adbus_oe=0; RX_OE oe_n=0; RX_READ oe_n=0, rd_n per REQ-018; RX_TURN all high; TX_WRITE adbus_oe=1, wr_n per REQ-022.
REQ-015 IDLE: rx_ok = ~rxf_n & buffer count<=2; tx_ok = ~txe_n & hold_valid; if both, grant side opposite last_grant; else grant the one that is ok; neither -> stay IDLE.
REQ-016 RX grant: IDLE -> RX_OE (1 cycle) -> RX_READ; last_grant<=RX; burst counter cleared.
REQ-017 RX capture: every edge where rd_n==0 and rxf_n==0, adbus_in pushed into RX buffer, burst counter +1.
REQ-018 rd_n registered low for next cycle only if rxf_n==0, post-edge buffer count<=2, burst counter+captured<BURST_MAX; otherwise rd_n high and FSM -> RX_TURN.
REQ-019 RX_TURN lasts exactly 1 cycle, then IDLE; guarantees FT releases bus before adbus_oe can rise.
REQ-020 RX buffer: 4-entry FIFO; rx_valid = not empty; rx_data = head; pop on rx_valid & rx_ready; simultaneous push and pop legal, count unchanged; overflow impossible by REQ-018 and is an assertion failure.
REQ-021 TX hold register: 1 word; tx_ready = ~hold_valid | (hold consumed this cycle); loads tx_data on tx handshake in any state.
REQ-022 TX_WRITE: wr_n low and adbus_out=hold word whenever hold_valid; word consumed at edge with wr_n==0 and txe_n==0, burst counter +1; if txe_n==1 word is retained and re-presented.
REQ-023 TX_WRITE exit -> IDLE (wr_n high, adbus_oe low next cycle) when txe_n sampled high, hold empty with tx_valid low, or burst counter reaches BURST_MAX; last_grant<=TX.
REQ-024 Burst counter 8-bit, saturates at BURST_MAX, cleared on every grant.
REQ-025 adbus_oe and oe_n never both active in same cycle; checked by assertion.

Reset
REQ-026 rst_n low asynchronously forces: state=IDLE, rd_n=wr_n=oe_n=1, adbus_oe=0, adbus_out=0, RX buffer empty (rx_valid=0), hold_valid=0 (tx_ready=1 after release), last_grant=TX, burst counter=0.
REQ-027 Reset mid-burst discards buffered RX words and held TX word; no strobe glitch low on release; first grant no earlier than 2nd edge after release.

Structure
REQ-028 Package ft2232h_pkg holds state type, BURST_MAX default, RXBUF_DEPTH, grant enum.
REQ-029 Sub-module ft2232h_rx_buf: 4x8 synchronous FIFO with count output; everything else in ft2232h_bus_arbiter.

Verification
REQ-030 RX only: rxf_n low 10 cycles with bytes 0x45..0x4E, rx_ready=1 -> oe_n low 1 cycle before rd_n, 10 bytes out in order, RX_TURN then IDLE.
REQ-031 RX backpressure: rx_ready=0, rxf_n low -> exactly 3 words captured, rd_n high, no overflow; rx_ready=1 -> remaining words resume after new grant.
REQ-032 TX stall: stream 0x01..0x08, txe_n high on 4th word's edge -> 0x04 re-presented, FT model receives 0x01..0x08 once each.
REQ-033 Contention: rxf_n and txe_n low, tx_valid steady, BURST_MAX=4 -> alternating 4-word RX and TX bursts, first grant RX, adbus_oe/oe_n never overlap.
REQ-034 Reset mid-TX burst at word 3 -> wr_n high, adbus_oe low same cycle as rst_n fall; after release tx_ready=1, rx_valid=0, state IDLE.
